// File: rtl/netint_lane_packer.sv
// Lane packer: compacts valid input lanes into a residual store and emits full LANES-wide packets.
// Optional partial-packet flush is enabled by defining NETINT_PACKER_FLUSH_EN.
module netint_lane_packer #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  localparam int CNT_W = $clog2(LANES) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_mask,
  output logic [CNT_W-1:0]        occupancy
);

  // Handshakes: a beat is taken on a rising edge when in_valid-beat && in_ready;
  // a packet is taken when out_valid && out_ready, and is held stable until then.

  // Reset asserts asynchronously and is released two edges after rst_n rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic [DATA_W-1:0]       r_res [LANES];
  logic [CNT_W-1:0]        r_occ;
  logic                    r_out_valid;
  logic [LANES*DATA_W-1:0] r_out_data;
  logic [LANES-1:0]        r_out_mask;

  logic                    w_out_free;
  logic                    w_flush_eff;
  logic                    w_flush_fire;
  logic                    w_accept;
  logic                    w_packet;
  logic                    w_handshake;
  logic [CNT_W-1:0]        w_total;
  logic [DATA_W-1:0]       w_comb [2*LANES];
  logic [LANES*DATA_W-1:0] w_flush_data;
  logic [LANES-1:0]        w_flush_mask;

  assign w_out_free = !r_out_valid || out_ready;

`ifdef NETINT_PACKER_FLUSH_EN
  assign w_flush_eff  = flush;
  assign w_flush_fire = flush && w_out_free && (r_occ != '0);
`else
  assign w_flush_eff  = flush & 1'b0;
  assign w_flush_fire = 1'b0;
`endif

  assign in_ready    = w_out_free && !w_flush_eff;
  assign w_accept    = in_ready && w_rst_n;
  assign w_handshake = r_out_valid && out_ready;
  assign w_packet    = w_accept && (w_total >= CNT_W'(LANES));

  // Residual entries first, then valid input lanes in ascending order.
  always_comb begin
    int pos;
    for (int j = 0; j < 2*LANES; j++) w_comb[j] = '0;
    for (int j = 0; j < LANES; j++) begin
      if (j < int'(r_occ)) w_comb[j] = r_res[j];
    end
    pos = int'(r_occ);
    for (int i = 0; i < LANES; i++) begin
      if (in_valid[i]) begin
        w_comb[pos] = in_data[i*DATA_W +: DATA_W];
        pos = pos + 1;
      end
    end
    w_total = CNT_W'(pos);
  end

  always_comb begin
    w_flush_data = '0;
    w_flush_mask = '0;
    for (int j = 0; j < LANES; j++) begin
      if (j < int'(r_occ)) begin
        w_flush_data[j*DATA_W +: DATA_W] = r_res[j];
        w_flush_mask[j]                  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int j = 0; j < LANES; j++) r_res[j] <= '0;
      r_occ       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
    end else if (w_packet) begin
      r_out_valid <= 1'b1;
      r_out_mask  <= '1;
      for (int j = 0; j < LANES; j++) begin
        r_out_data[j*DATA_W +: DATA_W] <= w_comb[j];
        r_res[j]                       <= w_comb[LANES+j];
      end
      r_occ <= w_total - CNT_W'(LANES);
    end else if (w_flush_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_flush_data;
      r_out_mask  <= w_flush_mask;
      for (int j = 0; j < LANES; j++) r_res[j] <= '0;
      r_occ <= '0;
    end else begin
      if (w_accept) begin
        for (int j = 0; j < LANES; j++) r_res[j] <= w_comb[j];
        r_occ <= w_total;
      end
      // Idle output carries no data, so mask and lanes return to zero.
      if (w_handshake) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_mask  <= '0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_mask  = r_out_mask;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_netint_lane_packer.sv
// Directed bench for netint_lane_packer (LANES=16, DATA_W=32), with flush cases under NETINT_PACKER_FLUSH_EN.
module tb_netint_lane_packer;
  localparam int LANES  = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(LANES) + 1;
  localparam int DW     = LANES * DATA_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [LANES-1:0] in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [LANES-1:0] out_mask;
  logic [CNT_W-1:0] occupancy;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_d;

  netint_lane_packer #(.LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_seq(input logic [31:0] base);
    for (int i = 0; i < LANES; i++) in_data[i*DATA_W +: DATA_W] = base + i;
  endtask

  // Expected packet: lanes 0..n-1 take base+first .. base+first+n-1, starting at lane 'at'.
  task automatic exp_run(input int at, input logic [31:0] base, input int first, input int n);
    for (int j = 0; j < n; j++) exp_d[(at+j)*DATA_W +: DATA_W] = base + first + j;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_mask", DW'(out_mask), DW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_occupancy", DW'(occupancy), DW'(0));
    rst_n = 1'b1;
    repeat (3) step();

    // Full beat completes a packet in one cycle.
    in_valid = 16'hFFFF; set_seq(32'h0);
    step();
    exp_d = '0; exp_run(0, 32'h0, 0, 16);
    check("t1_out_valid", DW'(out_valid), DW'(1));
    check("t1_out_data", out_data, exp_d);
    check("t1_out_mask", DW'(out_mask), DW'(16'hFFFF));
    check("t1_occupancy", DW'(occupancy), DW'(0));
    in_valid = '0;
    step();
    check("t1_drain_valid", DW'(out_valid), DW'(0));
    check("t1_drain_mask", DW'(out_mask), DW'(0));
    check("t1_drain_data", out_data, '0);

    // Sparse beat: only lanes 0 and 2 are stored; junk elsewhere must be dropped.
    in_valid = 16'h0005;
    for (int i = 0; i < LANES; i++) in_data[i*DATA_W +: DATA_W] = 32'hDEAD0000 + i;
    in_data[0*DATA_W +: DATA_W] = 32'hA;
    in_data[2*DATA_W +: DATA_W] = 32'hB;
    step();
    check("t2_occ_sparse", DW'(occupancy), DW'(2));
    check("t2_valid_sparse", DW'(out_valid), DW'(0));
    in_valid = 16'hFFFF; set_seq(32'h100); out_ready = 1'b0;
    step();
    exp_d = '0;
    exp_d[0 +: DATA_W] = 32'hA;
    exp_d[DATA_W +: DATA_W] = 32'hB;
    exp_run(2, 32'h100, 0, 14);
    check("t2_out_valid", DW'(out_valid), DW'(1));
    check("t2_out_data", out_data, exp_d);
    check("t2_occupancy", DW'(occupancy), DW'(2));

    // Backpressure: input stalls, packet held.
    set_seq(32'h200);
    #1;
    check("t3_in_ready_low", DW'(in_ready), DW'(0));
    for (int c = 0; c < 3; c++) begin
      step();
      check("t3_hold_data", out_data, exp_d);
      check("t3_hold_occ", DW'(occupancy), DW'(2));
      check("t3_hold_ready", DW'(in_ready), DW'(0));
    end

    // Handshake plus completing accept in the same edge: no bubble.
    out_ready = 1'b1;
    #1;
    check("t4_in_ready_high", DW'(in_ready), DW'(1));
    step();
    exp_d = '0; exp_run(0, 32'h100, 14, 2); exp_run(2, 32'h200, 0, 14);
    check("t4_b2b_valid", DW'(out_valid), DW'(1));
    check("t4_b2b_data", out_data, exp_d);
    check("t4_b2b_occ", DW'(occupancy), DW'(2));
    in_valid = 16'h0100; set_seq(32'h300);
    step();
    check("t4_after_valid", DW'(out_valid), DW'(0));
    check("t4_after_occ", DW'(occupancy), DW'(3));
    in_valid = '0;

`ifdef NETINT_PACKER_FLUSH_EN
    flush = 1'b1;
    #1;
    check("t5_flush_in_ready", DW'(in_ready), DW'(0));
    step();
    flush = 1'b0;
    exp_d = '0; exp_run(0, 32'h200, 14, 2); exp_d[2*DATA_W +: DATA_W] = 32'h308;
    check("t5_flush_valid", DW'(out_valid), DW'(1));
    check("t5_flush_mask", DW'(out_mask), DW'(16'h0007));
    check("t5_flush_data", out_data, exp_d);
    check("t5_flush_occ", DW'(occupancy), DW'(0));
    step();
    check("t5_flush_drain", DW'(out_valid), DW'(0));
`else
    flush = 1'b1;
    #1;
    check("t5_noflush_ready", DW'(in_ready), DW'(1));
    step();
    flush = 1'b0;
    check("t5_noflush_valid", DW'(out_valid), DW'(0));
    check("t5_noflush_occ", DW'(occupancy), DW'(3));
    in_valid = 16'h1FFF; set_seq(32'h400);
    step();
    in_valid = '0;
    exp_d = '0; exp_run(0, 32'h200, 14, 2); exp_d[2*DATA_W +: DATA_W] = 32'h308;
    exp_run(3, 32'h400, 0, 13);
    check("t5_fill_data", out_data, exp_d);
    check("t5_fill_mask", DW'(out_mask), DW'(16'hFFFF));
    check("t5_fill_occ", DW'(occupancy), DW'(0));
    step();
`endif

    // Build occupancy 5 with a packet pending, then reset mid-cycle.
    in_valid = 16'h001F; set_seq(32'h600);
    step();
    check("t6_occ5_pre", DW'(occupancy), DW'(5));
    in_valid = 16'hFFFF; set_seq(32'h700); out_ready = 1'b0;
    step();
    in_valid = '0;
    exp_d = '0; exp_run(0, 32'h600, 0, 5); exp_run(5, 32'h700, 0, 11);
    check("t6_pkt_data", out_data, exp_d);
    check("t6_pkt_occ", DW'(occupancy), DW'(5));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", DW'(out_valid), DW'(0));
    check("t6_rst_data", out_data, '0);
    check("t6_rst_mask", DW'(out_mask), DW'(0));
    check("t6_rst_occ", DW'(occupancy), DW'(0));
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) step();
    in_valid = 16'h0001; set_seq(32'h800);
    step();
    in_valid = '0;
    check("t6_post_occ", DW'(occupancy), DW'(1));
    check("t6_post_valid", DW'(out_valid), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
